// File: rtl/sw_select_debouncer.sv
// Debounced switch-bank selector: synchronizes raw switches, debounces the
// pattern, and decodes it into a registered IDLE / SEL / ERR node selection.
module sw_select_debouncer #(
  parameter int unsigned N_SW         = 9,
  parameter int unsigned N_NODE       = 7,
  parameter int unsigned IDX_W        = 3,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW:0]    sw,
  output logic [IDX_W-1:0] index,
  output logic             valid,
  output logic             err,
  output logic             sel_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEL,
    ST_ERR
  } state_e;

  logic [N_SW:1]    sync1_q, sync2_q;
  logic [N_SW:1]    cand_q, cand_d;
  logic [N_SW:1]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  state_e           state_q, state_d;

  logic [IDX_W-1:0] index_q, index_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             sel_pulse_q, sel_pulse_d;

  logic [1:0]       ones;
  logic             bad;
  logic [IDX_W-1:0] pos;

  logic             unused_sw0;
  assign unused_sw0 = sw[0];

  // Counter parks at DEBOUNCE_CYC after acceptance so a stable pattern is
  // accepted once rather than every DEBOUNCE_CYC cycles.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
      accept = 1'b1;
      cnt_d  = CNT_W'(DEBOUNCE_CYC);
    end else if (cnt_q < CNT_W'(DEBOUNCE_CYC - 1)) begin
      cnt_d  = cnt_q + 1'b1;
    end
    acc_d = accept ? cand_q : acc_q;
  end

  // Saturating ones-count plus illegal-position flag over the accepted pattern.
  always_comb begin
    ones = '0;
    bad  = 1'b0;
    pos  = '0;
    for (int unsigned i = 1; i <= N_SW; i++) begin
      if (acc_d[i]) begin
        if (ones != 2'd2) ones = ones + 2'd1;
        if ((i - 1) >= N_NODE) bad = 1'b1;
        else                   pos = IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (ones == 2'd0)              state_d = ST_IDLE;
      else if (ones == 2'd1 && !bad) state_d = ST_SEL;
      else                           state_d = ST_ERR;
    end
  end

  always_comb begin
    index_d     = index_q;
    valid_d     = valid_q;
    err_d       = err_q;
    sel_pulse_d = 1'b0;
    if (accept) begin
      case (state_d)
        ST_SEL: begin
          index_d     = pos;
          valid_d     = 1'b1;
          err_d       = 1'b0;
          sel_pulse_d = (state_q != ST_SEL) || (pos != index_q);
        end
        ST_ERR: begin
          index_d = '0;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
        default: begin
          index_d = '0;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      index_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      sel_pulse_q <= 1'b0;
    end else begin
      sync1_q     <= sw[N_SW:1];
      sync2_q     <= sync1_q;
      cand_q      <= cand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      index_q     <= index_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      sel_pulse_q <= sel_pulse_d;
    end
  end

  assign index     = index_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign sel_pulse = sel_pulse_q;

endmodule

// File: tb/tb_sw_select_debouncer.sv
// Scoreboard bench for sw_select_debouncer: stimulus queues expected outputs
// tagged with an absolute cycle; a monitor compares them on falling edges.
module tb_sw_select_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sw;
  logic [2:0] index;
  logic       valid, err, sel_pulse;

  sw_select_debouncer #(
    .N_SW(9),
    .N_NODE(7),
    .IDX_W(3),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .index(index),
    .valid(valid),
    .err(err),
    .sel_pulse(sel_pulse)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        v;
    logic        e;
    logic [2:0]  idx;
    logic        p;
  } exp_t;

  exp_t        q[$];
  int unsigned t0;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input int unsigned rel, input logic v, input logic e,
                     input logic [2:0] idx, input logic p);
    exp_t x;
    x.cyc = t0 + rel; x.v = v; x.e = e; x.idx = idx; x.p = p;
    q.push_back(x);
  endtask

  task automatic drive(input logic [9:0] v);
    @(negedge clk);
    sw = v;
    t0 = cyc;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compares every expectation whose cycle has arrived.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        x = q.pop_front();
        n_chk++;
        if (x.cyc != cyc || valid !== x.v || err !== x.e ||
            index !== x.idx || sel_pulse !== x.p) begin
          n_fail++;
          $display("FAIL cyc%0d(due %0d): got valid=%b err=%b index=%0d sel_pulse=%b, want valid=%b err=%b index=%0d sel_pulse=%b",
                   cyc, x.cyc, valid, err, index, sel_pulse, x.v, x.e, x.idx, x.p);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    repeat (2) @(posedge clk);
    #1;
    t0 = cyc;
    chk(0, 0, 0, 3'd0, 0);                  // reset state
    @(negedge clk);
    rst_n = 1'b1;
    wait_neg(8);

    // Single selectable switch: sw[3] -> index 2
    drive(10'b00_0000_1000);
    chk(6, 0, 0, 3'd0, 0);
    chk(7, 1, 0, 3'd2, 1);
    chk(8, 1, 0, 3'd2, 0);
    chk(12, 1, 0, 3'd2, 0);
    wait_neg(13);

    // Direct move to sw[6] -> index 5
    drive(10'b00_0100_0000);
    chk(6, 1, 0, 3'd2, 0);
    chk(7, 1, 0, 3'd5, 1);
    chk(8, 1, 0, 3'd5, 0);
    wait_neg(10);

    // Release all -> IDLE, no pulse
    drive(10'b00_0000_0000);
    chk(6, 1, 0, 3'd5, 0);
    chk(7, 0, 0, 3'd0, 0);
    chk(8, 0, 0, 3'd0, 0);
    wait_neg(10);

    // 3-cycle glitch on sw[1] is ignored
    drive(10'b00_0000_0010);
    chk(4, 0, 0, 3'd0, 0);
    chk(7, 0, 0, 3'd0, 0);
    chk(8, 0, 0, 3'd0, 0);
    chk(10, 0, 0, 3'd0, 0);
    chk(14, 0, 0, 3'd0, 0);
    wait_neg(2);
    @(negedge clk);
    sw = '0;
    wait_neg(14);

    // Two switches on -> ERR
    drive(10'b00_0000_0110);
    chk(6, 0, 0, 3'd0, 0);
    chk(7, 0, 1, 3'd0, 0);
    chk(9, 0, 1, 3'd0, 0);
    wait_neg(10);

    drive(10'b00_0000_0000);
    chk(7, 0, 0, 3'd0, 0);
    wait_neg(10);

    // Non-selectable sw[8] alone -> ERR, then sw[5] -> index 4 with a pulse
    drive(10'b01_0000_0000);
    chk(6, 0, 0, 3'd0, 0);
    chk(7, 0, 1, 3'd0, 0);
    chk(8, 0, 1, 3'd0, 0);
    wait_neg(10);

    drive(10'b00_0010_0000);
    chk(6, 0, 1, 3'd0, 0);
    chk(7, 1, 0, 3'd4, 1);
    chk(8, 1, 0, 3'd4, 0);
    wait_neg(10);

    // Brief disturbance returning to sw[5]: re-acceptance of same index, no pulse
    drive(10'b00_0010_0100);
    for (int unsigned r = 1; r <= 14; r++) chk(r, 1, 0, 3'd4, 0);
    wait_neg(1);
    @(negedge clk);
    sw = 10'b00_0010_0000;
    wait_neg(14);

    // Highest switch sw[9] -> ERR; then sw[7] (last selectable node) -> index 6
    drive(10'b10_0000_0000);
    chk(7, 0, 1, 3'd0, 0);
    wait_neg(10);

    drive(10'b00_1000_0000);
    chk(6, 0, 1, 3'd0, 0);
    chk(7, 1, 0, 3'd6, 1);
    chk(8, 1, 0, 3'd6, 0);
    wait_neg(10);

    // Reset in the middle of debouncing sw[4]
    drive(10'b00_0001_0000);
    wait_neg(3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    t0 = cyc;
    chk(0, 0, 0, 3'd0, 0);                  // asynchronous clear, no edge yet
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    chk(1, 0, 0, 3'd0, 0);
    chk(6, 0, 0, 3'd0, 0);
    chk(7, 1, 0, 3'd3, 1);
    chk(8, 1, 0, 3'd3, 0);
    wait_neg(10);

    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
